ecc_core_ctrl: RTL and testbench

// - Sequencer for one ECC transaction: accepts a command, loads the receive byte counter,

---
 rtl/ecc_ctrl_pkg.sv | 19 +
 rtl/ecc_ctrl_wdog.sv | 33 +++
 rtl/ecc_core_ctrl.sv | 143 ++++++++++++++
 tb/tb_ecc_core_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared definitions for the ECC transaction controller: FSM state encoding and default widths.
// Compile with ECC_CTRL_TIMEOUT_EN defined to build the watchdog/abort path.
package ecc_ctrl_pkg;

  localparam int SIZE_W_DEF         = 16;
  localparam int RSP_WORDS_DEF      = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  // ST_ERR is reachable only when the watchdog is built in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RECV = 3'd2,
    ST_CALC = 3'd3,
    ST_SEND = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/ecc_ctrl_wdog.sv
// Watchdog counter for the ECC controller: counts enabled, uncleared cycles and flags the
// TIMEOUT_CYCLES-th consecutive one. Used only when ECC_CTRL_TIMEOUT_EN is defined.
module ecc_ctrl_wdog
  import ecc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of idle cycles already seen, so this cycle is the last allowed one.
  assign o_expired = i_en && !i_clr && (r_cnt == LAST_CNT);

endmodule

// File: rtl/ecc_core_ctrl.sv
// ecc_core_ctrl: sequences one ECC transaction (command accept, receive, calc, result readout).
// Define ECC_CTRL_TIMEOUT_EN to build the watchdog that aborts stalled RECV/CALC phases.
module ecc_core_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int SIZE_W         = SIZE_W_DEF,
  parameter int RSP_WORDS      = RSP_WORDS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [SIZE_W-1:0] cmd_size,
  output logic              cmd_ready,
  input  logic              wr_en,
  output logic              rcv_load,
  output logic [SIZE_W-1:0] rcv_size,
  output logic              rcv_wr_en,
  input  logic              rcv_done,
  output logic              calc_start,
  input  logic              calc_done,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state
);

  // Handshakes: a command transfers on a cycle with cmd_valid && cmd_ready, a result word on a
  // cycle with rd_req && rd_ack; cmd_ready/rd_req never look at their own valid/ack input.

  localparam int WCNT_W = $clog2(RSP_WORDS + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(RSP_WORDS - 1);

  state_e            r_state;
  state_e            w_next;
  logic [SIZE_W-1:0] r_size;
  logic [WCNT_W-1:0] r_word_cnt;
  logic              r_calc_first;
  logic              w_accept;
  logic              w_last;
  logic              w_timeout;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_last   = (r_word_cnt == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_size       <= '0;
      r_word_cnt   <= '0;
      r_calc_first <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_calc_first <= (r_state != ST_CALC) && (w_next == ST_CALC);
      if (w_accept) begin
        r_size <= cmd_size;
      end
      if ((r_state == ST_CALC) && (w_next == ST_SEND)) begin
        r_word_cnt <= '0;
      end else if ((r_state == ST_SEND) && rd_ack) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  // calc_done in the calc_start cycle may be stale from the previous job, so it is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_RECV;
      ST_RECV: begin
        if (rcv_done) begin
          w_next = ST_CALC;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_CALC: begin
        if (!r_calc_first && calc_done) begin
          w_next = ST_SEND;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_SEND: if (rd_ack && w_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign rcv_load   = (r_state == ST_LOAD) || (r_state == ST_ERR);
  assign rcv_size   = r_size;
  assign rcv_wr_en  = wr_en && (r_state == ST_RECV);
  assign calc_start = (r_state == ST_CALC) && r_calc_first;
  assign rd_req     = (r_state == ST_SEND);
  assign done       = (r_state == ST_SEND) && rd_ack && w_last;
  assign dbg_state  = r_state;

`ifdef ECC_CTRL_TIMEOUT_EN
  logic w_wdog_en;
  logic w_wdog_clr;
  logic r_err;

  // Any activity, or leaving the phase, restarts the idle count.
  assign w_wdog_en  = (r_state == ST_RECV) || (r_state == ST_CALC);
  assign w_wdog_clr = !w_wdog_en
                   || ((r_state == ST_RECV) && (wr_en || rcv_done))
                   || ((r_state == ST_CALC) && calc_done);

  ecc_ctrl_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wdog_clr),
    .i_en     (w_wdog_en),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_next == ST_ERR) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYCLES > 1);
  assign w_timeout    = 1'b0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_core_ctrl.sv
// Self-checking bench for ecc_core_ctrl: directed scenarios plus randomized traffic against a
// transaction-level reference model; honours ECC_CTRL_TIMEOUT_EN like the design.
module tb_ecc_core_ctrl;
  import ecc_ctrl_pkg::*;

  localparam int SIZE_W    = 16;
  localparam int RSP_WORDS = 8;
  localparam int TMO       = 16;
`ifdef ECC_CTRL_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [SIZE_W-1:0] cmd_size = '0;
  logic              wr_en = 1'b0;
  logic              calc_done = 1'b0;
  logic              rd_ack = 1'b0;
  logic              rcv_done;
  logic              cmd_ready, rcv_load, rcv_wr_en, calc_start, rd_req, busy, done, err;
  logic [SIZE_W-1:0] rcv_size;
  state_e            dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  ecc_core_ctrl #(
    .SIZE_W(SIZE_W), .RSP_WORDS(RSP_WORDS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_size(cmd_size), .cmd_ready(cmd_ready),
    .wr_en(wr_en), .rcv_load(rcv_load), .rcv_size(rcv_size), .rcv_wr_en(rcv_wr_en),
    .rcv_done(rcv_done), .calc_start(calc_start), .calc_done(calc_done), .rd_req(rd_req),
    .rd_ack(rd_ack), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- receive byte counter environment ----------------
  logic              s_load, s_wr;
  logic [SIZE_W-1:0] s_size;
  logic [SIZE_W-1:0] env_cnt;

  assign rcv_done = (env_cnt == '0);

  always @(posedge clk or posedge rst) begin
    if (rst) env_cnt <= '0;
    else if (s_load) env_cnt <= s_size;
    else if (s_wr) env_cnt <= (env_cnt > 16'd4) ? env_cnt - 16'd4 : '0;
  end

  // ---------------- reference model ----------------
  typedef enum int {PH_IDLE, PH_LOAD, PH_RECV, PH_CALC_FIRST, PH_CALC, PH_SEND, PH_ERR} phase_t;
  phase_t            ph;
  logic [SIZE_W-1:0] m_size;
  int                m_words;
  int                m_idle;
  logic              m_err;
  logic [SIZE_W-1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = PH_IDLE; m_size = '0; m_words = 0; m_idle = 0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      case (ph)
        PH_IDLE: if (cmd_valid) begin
          ph = PH_LOAD; m_size = cmd_size; m_err = 1'b0; exp_q.push_back(cmd_size);
        end
        PH_LOAD: begin ph = PH_RECV; m_idle = 0; end
        PH_RECV: begin
          if (rcv_done) begin ph = PH_CALC_FIRST; m_idle = 0; end
          else if (wr_en) m_idle = 0;
          else begin
            m_idle++;
            if (TMO_ON && m_idle == TMO) begin ph = PH_ERR; m_err = 1'b1; end
          end
        end
        PH_CALC_FIRST: begin
          m_idle = calc_done ? 0 : m_idle + 1;
          ph = PH_CALC;
        end
        PH_CALC: begin
          if (calc_done) begin ph = PH_SEND; m_words = 0; end
          else begin
            m_idle++;
            if (TMO_ON && m_idle == TMO) begin ph = PH_ERR; m_err = 1'b1; end
          end
        end
        PH_SEND: if (rd_ack) begin
          if (m_words == RSP_WORDS - 1) ph = PH_IDLE;
          m_words++;
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0]        cmp_act, cmp_exp;
  logic [SIZE_W-1:0] cmp_size, sb_val;

  always @(negedge clk) begin
    s_load = rcv_load; s_wr = rcv_wr_en; s_size = rcv_size;
    cmp_act = {cmd_ready, rcv_load, rcv_wr_en, calc_start, rd_req, busy, done, err};
    if (rst) begin
      cmp_exp  = 8'b1000_0000;
      cmp_size = '0;
    end else begin
      cmp_exp = {ph == PH_IDLE, (ph == PH_LOAD) || (ph == PH_ERR), (ph == PH_RECV) && wr_en,
                 ph == PH_CALC_FIRST, ph == PH_SEND, ph != PH_IDLE,
                 (ph == PH_SEND) && rd_ack && (m_words == RSP_WORDS - 1), m_err};
      cmp_size = m_size;
      if (ph == PH_LOAD && exp_q.size() > 0) begin
        sb_val = exp_q.pop_front();
        chk("sb_load_size", rcv_size, sb_val);
      end
    end
    chk("outputs{rdy,load,wr,start,req,busy,done,err}", cmp_act, cmp_exp);
    chk("rcv_size", rcv_size, cmp_size);
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [SIZE_W-1:0] size);
    cmd_valid = 1'b1; cmd_size = size;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic complete_txn(input string tag);
    int n = 0;
    bit seen = 0;
    wr_en = 1'b1; calc_done = 1'b1; rd_ack = 1'b1;
    while (!seen && n < 200) begin
      #1;
      if (done) seen = 1;
      step();
      n++;
    end
    wr_en = 1'b0; calc_done = 1'b0; rd_ack = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    #1;
    chk({tag, "_idle_after"}, cmd_ready, 1);
  endtask

  task automatic test_basic();
    send_cmd(16'd12);
    chk("a_load_latency", rcv_load, 1);
    step();
    chk("a_load_single", rcv_load, 0);
    wr_en = 1'b1;
    repeat (3) step();
    wr_en = 1'b0;
    chk("a_recv_until_done", calc_start, 0);
    step();
    chk("a_calc_start", calc_start, 1);
    calc_done = 1'b1;
    step();
    chk("a_calc_start_single", calc_start, 0);
    chk("a_no_same_cycle_send", rd_req, 0);
    step();
    chk("a_send_entry", rd_req, 1);
    calc_done = 1'b0;
    rd_ack = 1'b1;
    for (int k = 0; k < RSP_WORDS; k++) begin
      #1;
      chk("a_done_on_last_ack", done, (k == RSP_WORDS - 1));
      step();
    end
    rd_ack = 1'b0;
    #1;
    chk("a_idle_after_done", cmd_ready, 1);
  endtask

  task automatic test_zero_size();
    int acks = 0;
    int n = 0;
    bit seen = 0;
    wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b_idle_wr_dropped", rcv_wr_en, 0);
      step();
    end
    wr_en = 1'b0;
    send_cmd(16'd0);
    chk("b_load", rcv_load, 1);
    step();
    chk("b_one_recv_cycle", calc_start, 0);
    chk("b_busy", busy, 1);
    step();
    chk("b_calc_start_no_wr", calc_start, 1);
    step();
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
    chk("b_send", rd_req, 1);
    for (int k = 0; k < 3; k++) begin
      chk("b_stall_keeps_req", rd_req, 1);
      step();
    end
    while (!seen && n < 100) begin
      rd_ack = 1'($urandom_range(0, 1));
      #1;
      if (rd_ack) acks++;
      if (done) seen = 1;
      step();
      n++;
    end
    rd_ack = 1'b0;
    chk("b_done_seen", seen, 1);
    chk("b_ack_count", acks, RSP_WORDS);
  endtask

  task automatic test_timeout();
    int n = 0;
    send_cmd(16'd8);
    step();
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    while (!rcv_load && n < 60) begin
      step();
      n++;
    end
`ifdef ECC_CTRL_TIMEOUT_EN
    chk("c_timeout_cycles", n, TMO);
    chk("c_err_in_abort", err, 1);
    step();
    chk("c_err_sticky", err, 1);
    chk("c_idle_after_abort", cmd_ready, 1);
    send_cmd(16'd4);
    chk("c_err_cleared", err, 0);
`else
    chk("c_stays_busy", busy, 1);
    chk("c_no_flush", rcv_load, 0);
    chk("c_no_err", err, 0);
    chk("c_no_send", rd_req, 0);
`endif
    complete_txn("c");
  endtask

  task automatic test_reset_mid_send();
    int n = 0;
    send_cmd(16'd4);
    wr_en = 1'b1; calc_done = 1'b1;
    while (!rd_req && n < 20) begin
      step();
      n++;
    end
    wr_en = 1'b0; calc_done = 1'b0;
    chk("d_in_send", rd_req, 1);
    rd_ack = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("d_rst_ready", cmd_ready, 1);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_req", rd_req, 0);
    chk("d_rst_done", done, 0);
    chk("d_rst_err", err, 0);
    chk("d_rst_size", rcv_size, 0);
    step();
    rd_ack = 1'b0;
    rst = 1'b0;
    send_cmd(16'd20);
    complete_txn("d");
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_size  = SIZE_W'($urandom_range(0, 40));
      rd_ack    = 1'($urandom_range(0, 1));
      if ((i % 600) < 100) begin
        wr_en = 1'b0; calc_done = 1'b0;
      end else begin
        wr_en     = 1'($urandom_range(0, 1));
        calc_done = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    cmd_valid = 1'b0; wr_en = 1'b0; calc_done = 1'b0; rd_ack = 1'b0;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rcv_load", rcv_load, 0);
    chk("reset_calc_start", calc_start, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_rcv_size", rcv_size, 0);
    chk("reset_dbg_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    test_basic();
    test_zero_size();
    test_timeout();
    test_reset_mid_send();
    random_traffic(3000);
    repeat (3) step();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
